// File: rtl/fixed_point_div_seq.sv
// fixed_point_div_seq: multi-cycle signed Q(WIDTH-FRAC).FRAC restoring divider; define QDIV_SAT_EN to saturate on overflow instead of wrapping
module fixed_point_div_seq #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             div_by_zero
);
  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0] LIM_P = N'((2 ** (WIDTH - 1)) - 1);
  localparam logic [N-1:0] LIM_N = N'(2 ** (WIDTH - 1));
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t            r_state;
  logic              r_sign;
  logic [WIDTH-1:0]  r_den;
  logic [WIDTH:0]    r_rem;
  logic [N-1:0]      r_q;
  logic [CW-1:0]     r_cnt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_ovf;
  logic              r_dbz;
  logic [WIDTH-1:0]  r_result;
  logic [WIDTH-1:0]  w_abs_a;
  logic [WIDTH-1:0]  w_abs_b;
  logic [WIDTH+1:0]  w_rem_sh;
  logic [WIDTH+1:0]  w_diff;
  logic              w_bit;
  logic              w_ovf;
  logic [WIDTH-1:0]  w_wrap;
  logic [WIDTH-1:0]  w_res;
  // operand magnitudes, one restoring step, and the final sign/overflow fix-up
  always_comb begin
    w_abs_a  = a[WIDTH-1] ? -a : a;
    w_abs_b  = b[WIDTH-1] ? -b : b;
    w_rem_sh = {r_rem, r_q[N-1]};
    w_diff   = w_rem_sh - {2'b00, r_den};
    w_bit    = ~w_diff[WIDTH+1];
    w_ovf    = r_sign ? (r_q > LIM_N) : (r_q > LIM_P);
    w_wrap   = r_sign ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
`ifdef QDIV_SAT_EN
    w_res    = w_ovf ? (r_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : w_wrap;
`else
    w_res    = w_wrap;
`endif
  end
  // handshake FSM: accept, iterate one quotient bit per cycle, fix sign, hold result until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_in_ready <= 1'b0;
          r_sign     <= a[WIDTH-1] ^ b[WIDTH-1];
          r_den      <= w_abs_b;
          r_rem      <= '0;
          r_q        <= {w_abs_a, {FRAC{1'b0}}};
          r_cnt      <= CW'(N);
          r_ovf      <= 1'b0;
          r_dbz      <= (b == '0);
          if (b == '0) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_result    <= {1'b0, {(WIDTH-1){1'b1}}};
          end else begin
            r_state <= CALC;
          end
        end
        CALC: begin
          r_rem <= w_bit ? w_diff[WIDTH:0] : w_rem_sh[WIDTH:0];
          r_q   <= {r_q[N-2:0], w_bit};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= FIX;
        end
        FIX: begin
          r_result    <= w_res;
          r_ovf       <= w_ovf;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end
  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign overflow    = r_ovf;
  assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_fixed_point_div_seq.sv
// tb_fixed_point_div_seq: scoreboard bench for the sequential fixed-point divider
module tb_fixed_point_div_seq;
  logic        clk, rst, in_valid, in_ready, out_valid, out_ready, overflow, div_by_zero;
  logic [15:0] a, b, result;
  fixed_point_div_seq #(.WIDTH(16), .FRAC(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .div_by_zero(div_by_zero));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  logic [17:0] exp_q[$];
  int cyc = 0, acc_cyc = 0, exp_lat = 0;
  logic exp_ir = 1'b1, prev_ov = 1'b0, after_rst = 1'b0, to_flag = 1'b0;
  // reference: plain signed arithmetic on Q8.8 values, '/' truncates toward zero
  function automatic logic [17:0] model(input logic [15:0] xa, input logic [15:0] xb);
    longint q;
    logic [15:0] r;
    logic o;
    if (xb == 16'h0000) return {16'h7FFF, 1'b0, 1'b1};
    q = (longint'($signed(xa)) * 256) / longint'($signed(xb));
    o = (q > 32767) || (q < -32768);
    r = q[15:0];
`ifdef QDIV_SAT_EN
    if (o) r = (q > 0) ? 16'h7FFF : 16'h8000;
`endif
    return {r, o, 1'b0};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // monitor: scoreboard pop/compare, handshake and latency tracking
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      exp_ir = 1'b1;
      prev_ov = 1'b0;
      after_rst = 1'b1;
    end else begin
      if (after_rst) begin
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_result", {16'b0, result}, 0);
        chk("rst_flags", {30'b0, overflow, div_by_zero}, 0);
        after_rst = 1'b0;
      end
      chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ir});
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", {31'b0, out_valid}, 0);
      end else if (out_valid) begin
        if (!prev_ov) chk("latency", cyc - acc_cyc, exp_lat);
        chk("result", {16'b0, result}, {16'b0, exp_q[0][17:2]});
        chk("overflow", {31'b0, overflow}, {31'b0, exp_q[0][1]});
        chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, exp_q[0][0]});
      end else if (!to_flag && (cyc - acc_cyc > exp_lat)) begin
        chk("latency_timeout", {31'b0, out_valid}, 1);
        to_flag = 1'b1;
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        exp_ir = 1'b1;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b));
        acc_cyc = cyc;
        exp_lat = (b == 16'h0000) ? 1 : 26;
        exp_ir = 1'b0;
        to_flag = 1'b0;
      end
      prev_ov = out_valid;
    end
  end
  task automatic op(input logic [15:0] xa, input logic [15:0] xb, input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    a = xa;
    b = xb;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < hold; i++) begin
      if (i == 3) begin a = ~xa; b = 16'h0100; in_valid = 1'b1; end
      if (i == 4) in_valid = 1'b0;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask
  logic [15:0] dir_a[11] = '{16'h0300, 16'h0100, 16'hFF00, 16'hFD00, 16'h1234, 16'h8000,
                             16'h7FFF, 16'h8000, 16'h8000, 16'h0000, 16'hFFFF};
  logic [15:0] dir_b[11] = '{16'h0200, 16'h0300, 16'h0300, 16'h0200, 16'h0000, 16'h0000,
                             16'h0080, 16'hFF00, 16'h0100, 16'h0700, 16'h8000};
  initial begin
    logic [15:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 11; i++) op(dir_a[i], dir_b[i], 0);
    op(16'h0A00, 16'hFD00, 10);
    op(16'h0000, 16'h0000, 10);
    while (!in_ready) begin @(posedge clk); #1; end
    a = 16'h1234; b = 16'h0100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    op(16'h0500, 16'h0100, 0);
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0: rb = 16'h0000;
        1: rb = 16'($urandom_range(1, 255));
        2: rb = 16'(-$urandom_range(1, 255));
        default: rb = 16'($urandom);
      endcase
      op(ra, rb, (i % 7 == 0) ? 3 : 0);
    end
    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
